// File: rtl/adaptive_phase_ctrl.sv
// rtl/adaptive_phase_ctrl.sv - N-phase adaptive traffic-light sequencer
// Round-robin greens extended by windowed car counts, with demand-based phase skipping.
module adaptive_phase_ctrl #(
  parameter int NPH       = 3,
  parameter int CW        = 4,
  parameter int GREEN_MIN = 8,
  parameter int WIN_T     = 4,
  parameter int EXT_UNIT  = 2,
  parameter int EXT_CAP   = 16,
  parameter int EXT_MAX   = 3,
  parameter int YELLOW_T  = 6,
  parameter int ALLRED_T  = 20,
  parameter int SKIP_EN   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NPH*CW-1:0]            car_cnt,
  output logic [3*NPH-1:0]             lights,
  output logic [$clog2(NPH)-1:0]       phase_idx,
  output logic [2:0]                   state,
  output logic [$clog2(EXT_MAX+1)-1:0] ext_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PIW  = $clog2(NPH);
  localparam int EW   = $clog2(EXT_MAX + 1);
  localparam int PW   = CW + $clog2(EXT_UNIT + 1);
  localparam int DMAX = max2(max2(max2(ALLRED_T, GREEN_MIN), max2(WIN_T, EXT_CAP)), YELLOW_T);
  localparam int DW   = $clog2(DMAX + 1);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_WINDOW = 3'd2,
    S_EXTEND = 3'd3,
    S_YELLOW = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       timer_q, timer_d;
  logic [PIW-1:0]      phase_q, phase_d;
  logic [EW-1:0]       ext_q, ext_d;
  logic [DW-1:0]       ext_len_q, ext_len_d;
  logic [CW-1:0]       snap_q, snap_d;
  logic [NPH-1:0]      demand_q, demand_d;
  logic [NPH*CW-1:0]   car_prev_q;

  logic [CW-1:0]       car_cur;
  logic [CW-1:0]       delta;
  logic [PW-1:0]       prod;
  logic [DW-1:0]       ext_sat;
  logic [DW-1:0]       dur;
  logic [PIW-1:0]      nxt_phase;
  logic [PIW-1:0]      scan_idx;
  logic [NPH-1:0]      chg;
  logic [NPH-1:0]      clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_ALLRED;
      timer_q    <= '0;
      phase_q    <= PIW'(NPH - 1);
      ext_q      <= '0;
      ext_len_q  <= '0;
      snap_q     <= '0;
      demand_q   <= '1;
      car_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      ext_q      <= ext_d;
      ext_len_q  <= ext_len_d;
      snap_q     <= snap_d;
      demand_q   <= demand_d;
      car_prev_q <= car_cnt;
    end
  end

  // Counter of the phase currently holding green, and its windowed growth.
  always_comb begin
    car_cur = '0;
    for (int p = 0; p < NPH; p++) begin
      if (PIW'(p) == phase_q) car_cur = car_cnt[p*CW +: CW];
    end
    delta   = car_cur - snap_q;
    prod    = PW'(delta) * PW'(EXT_UNIT);
    ext_sat = (32'(prod) > 32'(EXT_CAP)) ? DW'(EXT_CAP) : DW'(prod);
  end

  // Closest phase after the current one with pending demand; lowest offset wins.
  always_comb begin
    nxt_phase = PIW'((int'(phase_q) + 1) % NPH);
    scan_idx  = '0;
    if (SKIP_EN != 0) begin
      for (int i = NPH; i >= 1; i--) begin
        scan_idx = PIW'((int'(phase_q) + i) % NPH);
        if (demand_q[scan_idx]) nxt_phase = scan_idx;
      end
    end
  end

  always_comb begin
    case (state_q)
      S_ALLRED: dur = DW'(ALLRED_T);
      S_GREEN:  dur = DW'(GREEN_MIN);
      S_WINDOW: dur = DW'(WIN_T);
      S_EXTEND: dur = ext_len_q;
      S_YELLOW: dur = DW'(YELLOW_T);
      default:  dur = DW'(ALLRED_T);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    phase_d   = phase_q;
    ext_d     = ext_q;
    ext_len_d = ext_len_q;
    snap_d    = snap_q;
    clr       = '0;
    if (tick) begin
      if (timer_q != dur - DW'(1)) begin
        timer_d = timer_q + DW'(1);
      end else begin
        timer_d = '0;
        case (state_q)
          S_ALLRED: begin
            state_d = S_GREEN;
            phase_d = nxt_phase;
            ext_d   = '0;
            clr     = NPH'(1) << nxt_phase;
          end
          S_GREEN: begin
            state_d = S_WINDOW;
            snap_d  = car_cur;
          end
          S_WINDOW: begin
            if (delta == '0 || ext_q == EW'(EXT_MAX)) begin
              state_d = S_YELLOW;
            end else begin
              state_d   = S_EXTEND;
              ext_len_d = ext_sat;
              ext_d     = ext_q + EW'(1);
            end
          end
          S_EXTEND: begin
            state_d = S_WINDOW;
            snap_d  = car_cur;
          end
          default: state_d = S_ALLRED;
        endcase
      end
    end
  end

  // Demand tracks counter motion every clock, independent of tick; clear wins.
  always_comb begin
    chg = '0;
    for (int p = 0; p < NPH; p++) begin
      chg[p] = car_cnt[p*CW +: CW] != car_prev_q[p*CW +: CW];
    end
    demand_d = (demand_q | chg) & ~clr;
  end

  always_comb begin
    lights = '0;
    for (int p = 0; p < NPH; p++) begin
      lights[3*p +: 3] = 3'b001;
      if (PIW'(p) == phase_q) begin
        if (state_q == S_GREEN || state_q == S_WINDOW || state_q == S_EXTEND)
          lights[3*p +: 3] = 3'b100;
        else if (state_q == S_YELLOW)
          lights[3*p +: 3] = 3'b010;
      end
    end
  end

  assign phase_idx = phase_q;
  assign state     = state_q;
  assign ext_cnt   = ext_q;

endmodule

// File: tb/tb_adaptive_phase_ctrl.sv
// tb/tb_adaptive_phase_ctrl.sv - scoreboard bench for adaptive_phase_ctrl
module tb_adaptive_phase_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b1;
  logic [11:0] car_cnt = '0;
  logic [8:0]  lights_a, lights_b;
  logic [1:0]  phase_a, phase_b;
  logic [2:0]  state_a, state_b;
  logic [1:0]  ext_a, ext_b;

  adaptive_phase_ctrl #(.SKIP_EN(1)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .car_cnt(car_cnt),
    .lights(lights_a), .phase_idx(phase_a), .state(state_a), .ext_cnt(ext_a)
  );

  adaptive_phase_ctrl #(.SKIP_EN(0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .car_cnt(car_cnt),
    .lights(lights_b), .phase_idx(phase_b), .state(state_b), .ext_cnt(ext_b)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] AR = 3'd0, GR = 3'd1, WI = 3'd2, EX = 3'd3, YE = 3'd4;

  typedef struct {
    logic [2:0] st;
    logic [1:0] ph;
    logic [1:0] ext;
    int         len;
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   seg_no = 0;

  function automatic logic [8:0] exp_lights(input logic [2:0] st, input logic [1:0] ph);
    logic [8:0] l;
    for (int p = 0; p < 3; p++) begin
      l[3*p +: 3] = 3'b001;
      if (p == int'(ph) && (st == GR || st == WI || st == EX)) l[3*p +: 3] = 3'b100;
      if (p == int'(ph) && st == YE) l[3*p +: 3] = 3'b010;
    end
    return l;
  endfunction

  // Monitor: a segment is a run of cycles with constant (state, phase, ext).
  logic       mon_run = 1'b0;
  logic [2:0] c_st;
  logic [1:0] c_ph, c_ext;
  logic [8:0] c_l;
  int         c_len;

  task automatic close_seg();
    seg_t e;
    seg_no++;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL seg%0d unexpected: got st=%0d ph=%0d ext=%0d len=%0d, want none",
               seg_no, c_st, c_ph, c_ext, c_len);
    end else begin
      e = exp_q.pop_front();
      if (c_st !== e.st || c_ph !== e.ph || c_ext !== e.ext || c_len != e.len) begin
        failures++;
        $display("FAIL seg%0d: got st=%0d ph=%0d ext=%0d len=%0d, want st=%0d ph=%0d ext=%0d len=%0d",
                 seg_no, c_st, c_ph, c_ext, c_len, e.st, e.ph, e.ext, e.len);
      end
      checks++;
      if (c_l !== exp_lights(e.st, e.ph)) begin
        failures++;
        $display("FAIL seg%0d lights: got %b, want %b", seg_no, c_l, exp_lights(e.st, e.ph));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon_run = 1'b0;
    end else if (!mon_run || state_a !== c_st || phase_a !== c_ph || ext_a !== c_ext) begin
      if (mon_run) close_seg();
      mon_run = 1'b1;
      c_st = state_a; c_ph = phase_a; c_ext = ext_a; c_l = lights_a;
      c_len = 1;
    end else begin
      c_len++;
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] st, input logic [1:0] ph, input logic [1:0] ext, input int len);
    seg_t s;
    s.st = st; s.ph = ph; s.ext = ext; s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic push_cycle(input logic [1:0] ph);
    push(GR, ph, 2'd0, 8); push(WI, ph, 2'd0, 4); push(YE, ph, 2'd0, 6); push(AR, ph, 2'd0, 20);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_lights"}, int'(lights_a), 9'b001001001);
    check({name, "_state"}, int'(state_a), 0);
    check({name, "_phase"}, int'(phase_a), 2);
    check({name, "_ext"}, int'(ext_a), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick = 1'b1;
    car_cnt = '0;
    run(2);
    reset = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      run(1);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Round-robin with no traffic
    run(1);
    check_reset_state("rst0");
    do_reset();
    push(AR, 2'd2, 2'd0, 20);
    push_cycle(2'd0);
    push_cycle(2'd1);
    wait_empty("t1", 400);

    // One extension of 3 cars
    do_reset();
    push(AR, 2'd2, 2'd0, 20);
    push(GR, 2'd0, 2'd0, 8); push(WI, 2'd0, 2'd0, 4);
    push(EX, 2'd0, 2'd1, 6); push(WI, 2'd0, 2'd1, 4);
    push(YE, 2'd0, 2'd1, 6); push(AR, 2'd0, 2'd1, 20);
    run(29);
    car_cnt[3:0] = 4'd3;
    wait_empty("t2", 400);

    // Counter wrap (14 -> 1) then saturation (delta 9)
    do_reset();
    car_cnt[3:0] = 4'd14;
    push(AR, 2'd2, 2'd0, 20);
    push(GR, 2'd0, 2'd0, 8); push(WI, 2'd0, 2'd0, 4);
    push(EX, 2'd0, 2'd1, 6); push(WI, 2'd0, 2'd1, 4);
    push(EX, 2'd0, 2'd2, 16); push(WI, 2'd0, 2'd2, 4);
    push(YE, 2'd0, 2'd2, 6);
    run(29);
    car_cnt[3:0] = 4'd1;
    run(10);
    car_cnt[3:0] = 4'd10;
    wait_empty("t3", 400);

    // Continuous traffic caps at EXT_MAX extensions
    do_reset();
    push(AR, 2'd2, 2'd0, 20);
    push(GR, 2'd0, 2'd0, 8); push(WI, 2'd0, 2'd0, 4);
    push(EX, 2'd0, 2'd1, 8); push(WI, 2'd0, 2'd1, 4);
    push(EX, 2'd0, 2'd2, 8); push(WI, 2'd0, 2'd2, 4);
    push(EX, 2'd0, 2'd3, 8); push(WI, 2'd0, 2'd3, 4);
    push(YE, 2'd0, 2'd3, 6);
    repeat (80) begin
      run(1);
      car_cnt[3:0] = car_cnt[3:0] + 4'd1;
    end
    wait_empty("t4", 400);

    // Skipping: only ph2 has demand after the second ph0 green
    do_reset();
    push(AR, 2'd2, 2'd0, 20);
    push_cycle(2'd0);
    push_cycle(2'd1);
    push_cycle(2'd2);
    push_cycle(2'd0);
    push_cycle(2'd2);
    run(136);
    car_cnt[11:8] = 4'd1;
    run(39);
    check("t5_noskip_state", int'(state_b), 1);
    check("t5_noskip_phase", int'(phase_b), 1);
    wait_empty("t5", 300);

    // Tick gaps stretch durations; async reset aborts EXTEND
    do_reset();
    push(AR, 2'd2, 2'd0, 25);
    push(GR, 2'd0, 2'd0, 11);
    push(WI, 2'd0, 2'd0, 4);
    run(5);  tick = 1'b0;
    run(5);  tick = 1'b1;
    run(17); tick = 1'b0;
    run(3);  tick = 1'b1;
    run(7);  car_cnt[3:0] = 4'd2;
    run(4);
    check("t6_pre_drain", exp_q.size(), 0);
    check("t6_in_extend", int'(state_a), 3);
    #1 reset = 1'b1;
    #1;
    check_reset_state("t6_rst");
    check("t6_rst_b_lights", int'(lights_b), 9'b001001001);
    @(posedge clk);
    #1 reset = 1'b0;
    push(AR, 2'd2, 2'd0, 20);
    push(GR, 2'd0, 2'd0, 8);
    wait_empty("t6_after", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
